serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
- Downstream of the universal shift register. Consumes its serial output stream and reassembles framed n-bit words.
- Frame format: start marker, n data bits MSB first, even-parity bit.
- Good words go into a 2-entry output buffer, read through a valid/ready handshake.
- Parity failures and buffer overflows are reported as one-cycle pulses.

Parameters:
- n, 4, data word width in bits (n >= 2)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous active-low reset; clears all state
- sin  input  1  serial bit from the upstream shift register's sout
- sin_en  input  1  qualifies sin; a bit is consumed only on a clk edge with sin_en=1
- dout  output  n  word at the buffer head
- dout_valid  output  1  buffer not empty
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1
- busy  output  1  high while a frame is in progress (state != IDLE)
- perr  output  1  one-cycle pulse: frame parity mismatch, word dropped
- ovf  output  1  one-cycle pulse: good word dropped because buffer full
- count  output  2  buffer occupancy, 0..2

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bit counter=0, shift reg=0, buffer empty.
- Reset values of outputs: dout={n{1'b0}}, dout_valid=0, busy=0, perr=0, ovf=0, count=0.
- Reset asserted mid-frame aborts the frame. The partial word is discarded and no pulse is produced.
- Bits with sin_en=0 are ignored in every state. The FSM holds and gaps of any length are allowed.
- FSM states and transitions:
  - IDLE: sin_en=1 and sin=1 (start marker) -> DATA, counter=0. sin_en=1 and sin=0 is idle line; stay in IDLE.
  - DATA: each qualified bit shifts in, shreg <= {shreg[n-2:0],sin}, counter++. On the n-th bit -> PARITY.
  - PARITY: the qualified bit p is checked as ^shreg ^ p. Result 0 means the frame is good; result 1 is a parity error. The FSM returns to IDLE on the same edge.
- Good frame:
  - Push shreg into the buffer on the PARITY edge.
  - dout_valid is high after that edge; latency is 1 clk from the parity bit to dout_valid.
- Parity error: no push; perr=1 for exactly the cycle after the PARITY edge.
- Overflow: a good frame arriving with count=2 and no pop on the same edge is dropped. ovf=1 for one cycle.
- Simultaneous push and pop:
  - Both occur on the same edge, count is unchanged, and ordering is preserved.
  - At count=2 a same-edge pop frees a slot, so the push succeeds and there is no ovf.
- Pop with dout_valid=0 is ignored. dout is stable while dout_valid=1 and no pop occurs.
- Buffer: 2 entries, FIFO order, head visible on dout combinationally from the storage register.
- When empty, dout holds its last value. Consumers qualify it with dout_valid.
- busy=1 in DATA and PARITY.
- Back-to-back frames are legal: a start marker may arrive on the qualified bit immediately after parity.

Test Plan:
- n=4, reset, then qualified bits 1,1,0,1,0,0 (start, data 1010, parity 0) with dout_ready=0 -> dout_valid=1 and dout=4'b1010 one cycle after the parity bit; count=1; no perr.
- Same frame but parity bit 1 -> perr pulses once for 1 cycle; dout_valid stays 0; count=0.
- Three good frames (4'h3, 4'h5, 4'h9; parity 0,0,0) with dout_ready=0 -> count=2; ovf pulses on the third; popping then yields 3, then 5.
- count=2 with dout_ready=1 held, and a frame 4'hC completing on the same edge as a pop -> no ovf; count stays 2; subsequent pops yield 5, then C.
- Frame 1011 delivered with sin_en toggling 0/1 between every bit, plus idle 0s before the start -> dout=4'b1011; busy high from the start marker through the parity edge.
- Assert rst after 2 data bits of a frame, release, then send a full frame 4'h6 -> all outputs read 0 during reset; only 4'h6 appears; no perr or ovf.

Source files
------------

// File: rtl/serial_word_collector_if.sv
// rtl/serial_word_collector_if.sv - serial input and word output handshake bundle for serial_word_collector
interface serial_word_collector_if #(
    parameter int n = 4
) ();
    logic         sin;
    logic         sin_en;
    logic [n-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         perr;
    logic         ovf;
    logic [1:0]   count;

    modport master (
        output sin, sin_en, dout_ready,
        input  dout, dout_valid, busy, perr, ovf, count
    );

    modport slave (
        input  sin, sin_en, dout_ready,
        output dout, dout_valid, busy, perr, ovf, count
    );
endinterface

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - deframes start/data/even-parity serial frames into a 2-entry word buffer
module serial_word_collector #(
    parameter int n = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_collector_if.slave bus
);
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t        state;
    logic [CW-1:0] bitcnt;
    logic [n-1:0]  shreg;
    logic [n-1:0]  head;
    logic [n-1:0]  tail;
    logic [1:0]    count;
    logic          perr;
    logic          ovf;

    logic parity_bit;
    logic push;
    logic pop;

    assign parity_bit = bus.sin_en && (state == PARITY);
    assign push       = parity_bit && !(^shreg ^ bus.sin);
    assign pop        = (count != 2'd0) && bus.dout_ready;

    assign bus.dout       = head;
    assign bus.dout_valid = (count != 2'd0);
    assign bus.busy       = (state != IDLE);
    assign bus.perr       = perr;
    assign bus.ovf        = ovf;
    assign bus.count      = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            perr   <= 1'b0;
        end else begin
            perr <= 1'b0;
            if (bus.sin_en) begin
                case (state)
                    IDLE: begin
                        if (bus.sin) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {shreg[n-2:0], bus.sin};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == CW'(n - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        state  <= IDLE;
                        bitcnt <= '0;
                        perr   <= ^shreg ^ bus.sin;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // head always holds the oldest word; it is only overwritten by a push into an empty slot or a shift-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case ({push, pop})
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd2) begin
                        ovf <= 1'b1;
                    end else begin
                        if (count == 2'd0) head <= shreg;
                        else               tail <= shreg;
                        count <= count + 2'd1;
                    end
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= shreg;
                    end else begin
                        head <= tail;
                        tail <= shreg;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - directed and randomized frames checked against a frame-level model
module tb_serial_word_collector;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    serial_word_collector_if #(.n(N)) bus ();

    serial_word_collector #(.n(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [N-1:0] q[$];
    logic         bits[$];
    logic         active;
    logic [N-1:0] last_head;
    logic         exp_perr;
    logic         exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
        check({tag, "_valid"}, 32'(bus.dout_valid), 32'(q.size() != 0));
        check({tag, "_dout"}, 32'(bus.dout), 32'(last_head));
        check({tag, "_busy"}, 32'(bus.busy), 32'(active));
        check({tag, "_perr"}, 32'(bus.perr), 32'(exp_perr));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    endtask

    task automatic model_clear();
        q.delete();
        bits.delete();
        active = 1'b0;
        last_head = '0;
        exp_perr = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // one clock: drive inputs, advance, update the frame-level model, compare
    task automatic step(input logic s, input logic en, input logic rdy);
        logic         done;
        logic [N-1:0] w;
        logic         par;
        bus.sin = s;
        bus.sin_en = en;
        bus.dout_ready = rdy;
        @(posedge clk);
        done = 1'b0;
        w = '0;
        par = 1'b0;
        exp_perr = 1'b0;
        exp_ovf = 1'b0;
        if (en) begin
            if (!active) begin
                if (s) begin
                    active = 1'b1;
                    bits.delete();
                end
            end else begin
                bits.push_back(s);
                if (bits.size() == N + 1) begin
                    active = 1'b0;
                    done = 1'b1;
                    for (int i = 0; i < N; i++) w = {w[N-2:0], bits[i]};
                    par = (^w) ^ bits[N];
                end
            end
        end
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (done) begin
            if (par) exp_perr = 1'b1;
            else if (q.size() < 2) q.push_back(w);
            else exp_ovf = 1'b1;
        end
        if (q.size() > 0) last_head = q[0];
        #1;
        check_all("step");
    endtask

    task automatic send_bit(input logic b, input int gaps, input int rmode, input logic last);
        for (int g = 0; g < gaps; g++) step(1'(($urandom)), 1'b0, rmode == 2 ? 1'($urandom) : 1'b0);
        step(b, 1'b1, rmode == 2 ? 1'($urandom) : (rmode == 1 && last));
    endtask

    // rmode: 0 = never ready, 1 = ready only on the parity bit, 2 = random ready
    task automatic send_frame(input logic [N-1:0] w, input logic bad, input int gaps, input int rmode);
        send_bit(1'b1, gaps, rmode, 1'b0);
        for (int i = N - 1; i >= 0; i--) send_bit(w[i], gaps, rmode, 1'b0);
        send_bit((^w) ^ bad, gaps, rmode, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_clear();
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_valid", 32'(bus.dout_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_perr", 32'(bus.perr), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        check("rst_count", 32'(bus.count), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.sin = 1'b0;
        bus.sin_en = 1'b0;
        bus.dout_ready = 1'b0;
        model_clear();
        do_reset();

        // good frame 1010
        send_frame(4'b1010, 1'b0, 0, 0);
        check("t1_dout", 32'(bus.dout), 32'hA);
        check("t1_count", 32'(bus.count), 1);
        step(1'b0, 1'b0, 1'b1);

        // bad parity
        send_frame(4'b1010, 1'b1, 0, 0);
        check("t2_perr", 32'(bus.perr), 1);
        check("t2_count", 32'(bus.count), 0);
        step(1'b0, 1'b0, 1'b0);
        check("t2_perr_off", 32'(bus.perr), 0);

        // overflow on third word
        send_frame(4'h3, 1'b0, 0, 0);
        send_frame(4'h5, 1'b0, 0, 0);
        send_frame(4'h9, 1'b0, 0, 0);
        check("t3_ovf", 32'(bus.ovf), 1);
        check("t3_count", 32'(bus.count), 2);
        check("t3_head", 32'(bus.dout), 32'h3);

        // push at full with a same-edge pop
        send_frame(4'hC, 1'b0, 0, 1);
        check("t4_ovf", 32'(bus.ovf), 0);
        check("t4_count", 32'(bus.count), 2);
        check("t4_head", 32'(bus.dout), 32'h5);
        step(1'b0, 1'b0, 1'b1);
        check("t4_pop2", 32'(bus.dout), 32'hC);
        step(1'b0, 1'b0, 1'b1);
        check("t4_hold", 32'(bus.dout), 32'hC);

        // idle zeros then a gapped frame
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        send_frame(4'b1011, 1'b0, 1, 0);
        check("t5_dout", 32'(bus.dout), 32'hB);
        step(1'b0, 1'b0, 1'b1);

        // reset mid-frame
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        send_frame(4'h6, 1'b0, 0, 0);
        check("t6_dout", 32'(bus.dout), 32'h6);
        check("t6_count", 32'(bus.count), 1);

        // randomized frames, back-to-back allowed
        for (int k = 0; k < 40; k++) begin
            send_frame(N'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, 2), 2);
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 1'($urandom));
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
